// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave memory: configurable depth, byte-lane writes,
// programmable wait states, error response for out-of-range word addresses and
// cycle abort during wait states. Outputs are registered; memory is not reset.
module wb_slave_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth widened by one bit so DEPTH == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  // Wait counter counts down from WAIT_STATES-1; only used when WAIT_STATES > 0.
  localparam logic [7:0]          CntLoad  = 8'(WAIT_STATES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req;
  logic                  in_range;
  logic                  term;
  logic                  wr_en;
  logic [IdxW-1:0]       idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign req      = cyc_i & stb_i;
  assign in_range = ({1'b0, adr_i} < DepthExt);
  assign idx      = adr_i[IdxW-1:0];
  assign rd_word  = mem_q[idx];

  // Next-state, wait counter and termination decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    term    = 1'b0;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            term    = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = CntLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          // Master abandoned the cycle: drop it silently.
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          term    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        // Request inputs are ignored here; ack/err fall via the defaults.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    if (term) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!we_i) begin
          dat_d = rd_word;
        end
      end
    end
  end

  assign wr_en = term & in_range & we_i;

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane write into the storage array; blocked on a reset edge.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int n = 0; n < NumBytes; n++) begin
        if (sel_i[n]) begin
          mem_q[idx][8*n +: 8] <= dat_i[8*n +: 8];
        end
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: one instance with no wait states, one with three.
module tb_wb_slave_mem;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    bit          chk_dat;
    int          lat;
  } exp_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
    logic        extra;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
  logic [31:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(dat_w), .dat_o(dat0), .ack_o(ack0), .err_o(err0)
  );

  wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(dat_w), .dat_o(dat3), .ack_o(ack3), .err_o(err3)
  );

  // Drives one transfer, records the expected result and observes the response.
  task automatic do_xfer(input bit w3, input bit we_v, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input exp_t e,
                         output obs_t o);
    sb.push_back(e);
    @(negedge clk);
    we = we_v; adr = a; sel = s; dat_w = d;
    if (w3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else begin cyc0 = 1'b1; stb0 = 1'b1; end
    o.lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (w3 ? (ack3 | err3) : (ack0 | err0)) begin
        o.lat = i;
        break;
      end
    end
    o.ack = w3 ? ack3 : ack0;
    o.err = w3 ? err3 : err0;
    o.dat = w3 ? dat3 : dat0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    @(posedge clk); #1;
    o.extra = w3 ? (ack3 | err3) : (ack0 | err0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ack0, err0, dat0} !== 34'd0) begin
      bad++;
      $display("FAIL reset_ws0: ack=%b err=%b dat=%h, need 0 0 0", ack0, err0, dat0);
    end
    total++;
    if ({ack3, err3, dat3} !== 34'd0) begin
      bad++;
      $display("FAIL reset_ws3: ack=%b err=%b dat=%h, need 0 0 0", ack3, err3, dat3);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Table-driven transfers on the zero-wait instance: basic, byte lanes, out of range.
  task automatic test_ws0_table();
    logic        t_we  [13] = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    logic [31:0] t_adr [13] = '{3, 3, 5, 5, 5, 5, 5, 0, 0, 16, 32'hFFFF_FFFF, 0, 3};
    logic [3:0]  t_sel [13] = '{4'hF, 4'hF, 4'hF, 4'h5, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF,
                                4'hF, 4'hF, 4'h3};
    logic [31:0] t_dat [13] = '{32'hDEAD_BEEF, 0, 32'h1122_3344, 32'hAABB_CCDD, 0,
                                32'hFFFF_FFFF, 0, 32'h0BAD_F00D, 0, 32'h1234_5678, 0, 0, 0};
    logic        t_err [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    logic [31:0] t_exp [13] = '{0, 32'hDEAD_BEEF, 0, 0, 32'h11BB_33DD, 0, 32'h11BB_33DD, 0,
                                32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D,
                                32'hDEAD_BEEF};
    bit          t_chk [13] = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    exp_t e;
    obs_t o;
    for (int i = 0; i < 13; i++) begin
      e.ack = !t_err[i]; e.err = t_err[i]; e.dat = t_exp[i]; e.chk_dat = t_chk[i]; e.lat = 1;
      do_xfer(1'b0, t_we[i], t_adr[i], t_sel[i], t_dat[i], e, o);
      e = sb.pop_front();
      total++;
      if (o.ack !== e.ack || o.err !== e.err || o.lat != e.lat || o.extra !== 1'b0) begin
        bad++;
        $display("FAIL ws0_resp[%0d]: ack=%b err=%b lat=%0d extra=%b, need ack=%b err=%b lat=%0d extra=0",
                 i, o.ack, o.err, o.lat, o.extra, e.ack, e.err, e.lat);
      end
      if (e.chk_dat) begin
        total++;
        if (o.dat !== e.dat) begin
          bad++;
          $display("FAIL ws0_data[%0d]: dat=%h, need %h", i, o.dat, e.dat);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    obs_t o;
    int   got[$];
    int   want[$];
    e.ack = 1'b1; e.err = 1'b0; e.dat = 0; e.chk_dat = 0; e.lat = 4;
    do_xfer(1'b1, 1'b1, 32'd2, 4'hF, 32'hCAFE_0002, e, o);
    e.dat = 32'hCAFE_0002; e.chk_dat = 1;
    do_xfer(1'b1, 1'b0, 32'd2, 4'hF, 32'd0, e, o);
    e = sb.pop_front();
    e = sb.pop_front();
    total++;
    if (o.ack !== 1'b1 || o.err !== 1'b0 || o.lat != 4 || o.dat !== e.dat || o.extra !== 1'b0) begin
      bad++;
      $display("FAIL ws3_read: ack=%b err=%b lat=%0d dat=%h extra=%b, need 1 0 4 %h 0",
               o.ack, o.err, o.lat, o.dat, o.extra, e.dat);
    end
    // Back-to-back: stb held, acks expected on edges 4, 9, 14.
    want = '{4, 9, 14};
    @(negedge clk);
    we = 1'b0; adr = 32'd2; cyc3 = 1'b1; stb3 = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (ack3 === 1'b1) got.push_back(i);
    end
    @(negedge clk);
    cyc3 = 1'b0; stb3 = 1'b0;
    total++;
    if (got.size() != want.size()) begin
      bad++;
      $display("FAIL b2b_count: acks=%0d, need %0d", got.size(), want.size());
    end else begin
      foreach (want[k]) begin
        total++;
        if (got[k] != want[k]) begin
          bad++;
          $display("FAIL b2b_edge[%0d]: edge=%0d, need %0d", k, got[k], want[k]);
        end
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_abort();
    exp_t e;
    obs_t o;
    int   seen = 0;
    e.ack = 1'b1; e.err = 1'b0; e.dat = 0; e.chk_dat = 0; e.lat = 4;
    do_xfer(1'b1, 1'b1, 32'd7, 4'hF, 32'h7777_7777, e, o);
    e = sb.pop_front();
    @(negedge clk);
    we = 1'b1; adr = 32'd7; sel = 4'hF; dat_w = 32'h1212_1212; cyc3 = 1'b1; stb3 = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack3 | err3) seen++;
    end
    @(negedge clk);
    stb3 = 1'b0;
    @(posedge clk); #1;
    if (ack3 | err3) seen++;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_resp: responses=%0d, need 0", seen);
    end
    // New request on the very next edge must complete with the old contents.
    e.dat = 32'h7777_7777; e.chk_dat = 1;
    do_xfer(1'b1, 1'b0, 32'd7, 4'hF, 32'd0, e, o);
    e = sb.pop_front();
    total++;
    if (o.ack !== 1'b1 || o.lat != e.lat || o.dat !== e.dat) begin
      bad++;
      $display("FAIL abort_after: ack=%b lat=%0d dat=%h, need 1 %0d %h",
               o.ack, o.lat, o.dat, e.lat, e.dat);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    int   lat = -1;
    e.ack = 1'b1; e.err = 1'b0; e.dat = 0; e.chk_dat = 0; e.lat = 4;
    do_xfer(1'b1, 1'b1, 32'd8, 4'hF, 32'h8888_8888, e, o);
    e = sb.pop_front();
    // Reset while in WAIT during a write.
    @(negedge clk);
    we = 1'b1; adr = 32'd8; sel = 4'hF; dat_w = 32'h9999_9999; cyc3 = 1'b1; stb3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ack3, err3, dat3} !== 34'd0) begin
      bad++;
      $display("FAIL rst_wait: ack=%b err=%b dat=%h, need 0 0 0", ack3, err3, dat3);
    end
    @(negedge clk);
    rst = 1'b1; cyc3 = 1'b0; stb3 = 1'b0;
    e.dat = 32'h8888_8888; e.chk_dat = 1;
    do_xfer(1'b1, 1'b0, 32'd8, 4'hF, 32'd0, e, o);
    e = sb.pop_front();
    total++;
    if (o.ack !== 1'b1 || o.lat != 4 || o.dat !== e.dat) begin
      bad++;
      $display("FAIL rst_wait_after: ack=%b lat=%0d dat=%h, need 1 4 %h", o.ack, o.lat, o.dat, e.dat);
    end
    // Reset while in RESP after a read; dat_o must hold until the edge.
    @(negedge clk);
    we = 1'b0; adr = 32'd8; cyc3 = 1'b1; stb3 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack3) begin lat = i; break; end
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL rst_resp_lat: lat=%0d, need 4", lat);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (dat3 !== 32'h8888_8888) begin
      bad++;
      $display("FAIL rst_async: dat=%h, need 88888888", dat3);
    end
    @(posedge clk); #1;
    total++;
    if ({ack3, err3, dat3} !== 34'd0) begin
      bad++;
      $display("FAIL rst_resp: ack=%b err=%b dat=%h, need 0 0 0", ack3, err3, dat3);
    end
    // Write request presented at a reset edge on the zero-wait instance.
    @(negedge clk);
    cyc3 = 1'b0; stb3 = 1'b0;
    we = 1'b1; adr = 32'd3; sel = 4'hF; dat_w = 32'h0; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ack0, err0} !== 2'b00) begin
      bad++;
      $display("FAIL rst_edge_resp: ack=%b err=%b, need 0 0", ack0, err0);
    end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;
    #2;
    rst = 1'b1;
    e.ack = 1'b1; e.dat = 32'hDEAD_BEEF; e.chk_dat = 1; e.lat = 1;
    do_xfer(1'b0, 1'b0, 32'd3, 4'hF, 32'd0, e, o);
    e = sb.pop_front();
    total++;
    if (o.ack !== 1'b1 || o.lat != 1 || o.dat !== e.dat) begin
      bad++;
      $display("FAIL rst_no_write: ack=%b lat=%0d dat=%h, need 1 1 %h", o.ack, o.lat, o.dat, e.dat);
    end
    e.ack = 1'b1; e.dat = 32'h8888_8888; e.chk_dat = 1; e.lat = 4;
    do_xfer(1'b1, 1'b0, 32'd8, 4'hF, 32'd0, e, o);
    e = sb.pop_front();
    total++;
    if (o.ack !== 1'b1 || o.lat != 4 || o.dat !== e.dat || o.extra !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp_after: ack=%b lat=%0d dat=%h extra=%b, need 1 4 %h 0",
               o.ack, o.lat, o.dat, o.extra, e.dat);
    end
  endtask

  initial begin
    test_reset();
    test_ws0_table();
    test_wait_states();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
